// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences ALU, unified memory
// port and register file, and stretches memory states until memReady.
module mips_multicycle_ctrl #(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    op,
   input  logic               zero,
   input  logic               memReady,
   output logic               memWrite,
   output logic               IorD,
   output logic               IRWrite,
   output logic               pcEn,
   output logic               regWrite,
   output logic               regDst,
   output logic               memtoReg,
   output logic               aluSrcA,
   output logic [1:0]         aluSrcB,
   output logic [1:0]         aluOp,
   output logic [1:0]         pcSrc,
   output logic               illegal,
   output logic               retire,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } ctrlState_t;

   localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

   ctrlState_t curState, nextState;
   logic       pcWrite, branch;

   assign state = STATE_W'(curState);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) curState <= FETCH;
      else     curState <= nextState;
   end

   // Memory handshake: an access is presented for as long as the FSM sits in
   // FETCH/MEMREAD/MEMWRITE; it completes in the cycle memReady is 1, and only
   // that cycle may commit IRWrite, the PC increment or retire a store.
   always_comb begin
      nextState = curState;
      memWrite  = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      pcWrite   = 1'b0;
      branch    = 1'b0;
      regWrite  = 1'b0;
      regDst    = 1'b0;
      memtoReg  = 1'b0;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'b00;
      aluOp     = 2'b00;
      pcSrc     = 2'b00;
      illegal   = 1'b0;
      retire    = 1'b0;
      case (curState)
         FETCH: begin
            aluSrcB = 2'b01;
            IRWrite = memReady;
            pcWrite = memReady;
            if (memReady) nextState = DECODE;
         end
         DECODE: begin
            aluSrcB = 2'b11;
            if (op == OP_LW || op == OP_SW) nextState = MEMADR;
            else if (op == OP_R)            nextState = EXECUTE;
            else if (op == OP_BEQ)          nextState = BRANCH;
            else if (op == OP_ADDI)         nextState = ADDIEX;
            else if (op == OP_J)            nextState = JUMP;
            else begin
               nextState = FETCH;
               illegal   = 1'b1;
            end
         end
         MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            if (op == OP_SW)      nextState = MEMWRITE;
            else if (op == OP_LW) nextState = MEMREAD;
            else                  nextState = FETCH;
         end
         MEMREAD: begin
            IorD = 1'b1;
            if (memReady) nextState = MEMWB;
         end
         MEMWB: begin
            memtoReg  = 1'b1;
            regWrite  = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
         end
         MEMWRITE: begin
            IorD     = 1'b1;
            memWrite = 1'b1;
            retire   = memReady;
            if (memReady) nextState = FETCH;
         end
         EXECUTE: begin
            aluSrcA   = 1'b1;
            aluOp     = 2'b10;
            nextState = ALUWB;
         end
         ALUWB: begin
            regDst    = 1'b1;
            regWrite  = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
         end
         BRANCH: begin
            aluSrcA   = 1'b1;
            aluOp     = 2'b01;
            pcSrc     = 2'b01;
            branch    = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
         end
         ADDIEX: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'b10;
            nextState = ADDIWB;
         end
         ADDIWB: begin
            regWrite  = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
         end
         JUMP: begin
            pcSrc     = 2'b10;
            pcWrite   = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
         end
         default: nextState = FETCH;
      endcase
      // Reset overrides FETCH's Mealy terms so nothing strobes while held.
      if (rst) begin
         memWrite = 1'b0;
         IorD     = 1'b0;
         IRWrite  = 1'b0;
         pcWrite  = 1'b0;
         branch   = 1'b0;
         regWrite = 1'b0;
         regDst   = 1'b0;
         memtoReg = 1'b0;
         aluSrcA  = 1'b0;
         aluSrcB  = 2'b00;
         aluOp    = 2'b00;
         pcSrc    = 2'b00;
         illegal  = 1'b0;
         retire   = 1'b0;
      end
      pcEn = pcWrite | (branch & zero);
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle
// by cycle and compares state plus all control outputs against expected values.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic       zero;
   logic       memReady;
   logic       memWrite, IorD, IRWrite, pcEn, regWrite, regDst, memtoReg, aluSrcA;
   logic [1:0] aluSrcB, aluOp, pcSrc;
   logic       illegal, retire;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .memReady(memReady),
      .memWrite(memWrite), .IorD(IorD), .IRWrite(IRWrite), .pcEn(pcEn),
      .regWrite(regWrite), .regDst(regDst), .memtoReg(memtoReg),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc),
      .illegal(illegal), .retire(retire), .state(state)
   );

   always #5 clk = ~clk;

   // Packed order: memWrite IorD IRWrite pcEn regWrite regDst memtoReg aluSrcA
   //               aluSrcB aluOp pcSrc illegal retire
   function automatic logic [15:0] expVec(input logic [3:0] st, input logic mr,
                                          input logic z, input logic ill);
      case (st)
         4'd0:  return {1'b0, 1'b0, mr, mr, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
         4'd1:  return {8'h00, 2'b11, 2'b00, 2'b00, ill, 1'b0};
         4'd2:  return {8'h01, 2'b10, 2'b00, 2'b00, 2'b00};
         4'd3:  return {8'h40, 2'b00, 2'b00, 2'b00, 2'b00};
         4'd4:  return {8'h0A, 2'b00, 2'b00, 2'b00, 2'b01};
         4'd5:  return {8'hC0, 2'b00, 2'b00, 2'b00, 1'b0, mr};
         4'd6:  return {8'h01, 2'b00, 2'b10, 2'b00, 2'b00};
         4'd7:  return {8'h0C, 2'b00, 2'b00, 2'b00, 2'b01};
         4'd8:  return {3'b000, z, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b01};
         4'd9:  return {8'h01, 2'b10, 2'b00, 2'b00, 2'b00};
         4'd10: return {8'h08, 2'b00, 2'b00, 2'b00, 2'b01};
         4'd11: return {8'h10, 2'b00, 2'b00, 2'b10, 2'b01};
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] obsVec();
      return {memWrite, IorD, IRWrite, pcEn, regWrite, regDst, memtoReg, aluSrcA,
              aluSrcB, aluOp, pcSrc, illegal, retire};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One FSM cycle: apply inputs, check state and outputs mid-cycle, advance.
   task automatic cyc(input string tag, input logic [5:0] o, input logic mr,
                      input logic z, input logic [3:0] es, input logic ill);
      op = o; memReady = mr; zero = z;
      #1;
      chk({tag, ".state"}, {12'h000, state}, {12'h000, es});
      chk({tag, ".outs"}, obsVec(), expVec(es, mr, z, ill));
      @(posedge clk); #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; op = LW; zero = 1'b0; memReady = 1'b1;
      @(posedge clk); #2;
      chk("reset.state", {12'h000, state}, 16'h0000);
      chk("reset.outs", obsVec(), 16'h0000);
      rst = 1'b0;

      // lw, memReady held high, preceded by one stalled FETCH
      cyc("lw.fstall", LW, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc("lw.f",   LW, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("lw.d",   LW, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("lw.ma",  LW, 1'b1, 1'b0, 4'd2, 1'b0);
      cyc("lw.mr",  LW, 1'b1, 1'b0, 4'd3, 1'b0);
      cyc("lw.wb",  LW, 1'b1, 1'b0, 4'd4, 1'b0);

      // sw with two wait cycles in MEMWRITE
      cyc("sw.f",   SW, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("sw.d",   SW, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("sw.ma",  SW, 1'b1, 1'b0, 4'd2, 1'b0);
      cyc("sw.mw0", RT, 1'b0, 1'b0, 4'd5, 1'b0);
      cyc("sw.mw1", JMP, 1'b0, 1'b0, 4'd5, 1'b0);
      cyc("sw.mw2", BAD, 1'b1, 1'b0, 4'd5, 1'b0);

      // beq taken then not taken
      cyc("beq1.f", BEQ, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("beq1.d", BEQ, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("beq1.b", BEQ, 1'b1, 1'b1, 4'd8, 1'b0);
      cyc("beq0.f", BEQ, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("beq0.d", BEQ, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("beq0.b", BEQ, 1'b1, 1'b0, 4'd8, 1'b0);

      // R, addi, j
      cyc("r.f",    RT, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("r.d",    RT, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("r.ex",   RT, 1'b1, 1'b0, 4'd6, 1'b0);
      cyc("r.wb",   RT, 1'b1, 1'b0, 4'd7, 1'b0);
      cyc("ai.f",   ADDI, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("ai.d",   ADDI, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("ai.ex",  ADDI, 1'b1, 1'b0, 4'd9, 1'b0);
      cyc("ai.wb",  ADDI, 1'b1, 1'b0, 4'd10, 1'b0);
      cyc("j.f",    JMP, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("j.d",    JMP, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("j.j",    JMP, 1'b1, 1'b1, 4'd11, 1'b0);

      // illegal opcode
      cyc("ill.f",  BAD, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("ill.d",  BAD, 1'b1, 1'b0, 4'd1, 1'b1);
      cyc("ill.back", BAD, 1'b0, 1'b0, 4'd0, 1'b0);

      // async reset in the middle of a stalled MEMWRITE
      cyc("rsw.f",  SW, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("rsw.d",  SW, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("rsw.ma", SW, 1'b1, 1'b0, 4'd2, 1'b0);
      memReady = 1'b0;
      #1;
      chk("rsw.pre", obsVec(), expVec(4'd5, 1'b0, 1'b0, 1'b0));
      #1 rst = 1'b1;
      #1;
      chk("rsw.state", {12'h000, state}, 16'h0000);
      chk("rsw.outs", obsVec(), 16'h0000);
      @(posedge clk); #2;
      rst = 1'b0;
      cyc("post.fstall", LW, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc("post.f",      LW, 1'b1, 1'b0, 4'd0, 1'b0);
      cyc("post.d",      RT, 1'b1, 1'b0, 4'd1, 1'b0);
      cyc("post.ex",     RT, 1'b1, 1'b0, 4'd6, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
